// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared definitions for the gate sweep self-test controller: FSM state
// encoding, settle-counter width and reference truth tables for 2-input gates.
package gate_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  localparam int unsigned CNT_W = 4;

  // Bit i of each table is the expected output for input vector i (a = bit1, b = bit0).
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/and_gate.sv
// Two-input AND gate; the default combinational block exercised by gate_sweep_ctrl.
module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive self-test sequencer: walks every input vector of a combinational
// gate, waits a settle time, and tallies mismatches against a truth table.
module gate_sweep_ctrl
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int unsigned              N_IN   = 2,
  parameter int unsigned              SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]     EXPECT = TT_AND2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_seen,
  output logic [N_IN-1:0] first_fail
);

  localparam logic [N_IN-1:0]  LAST       = {N_IN{1'b1}};
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  sweep_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic             exp_bit;
  logic             mismatch;

  // An X/Z gate output never case-equals the expected bit, so it scores as a mismatch.
  always_comb begin
    exp_bit  = EXPECT[dut_in];
    mismatch = (dut_y !== exp_bit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_seen  <= 1'b0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dut_in     <= '0;
            cnt        <= SETTLE_CNT;
            err_count  <= '0;
            fail_seen  <= 1'b0;
            first_fail <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= CHECK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!fail_seen) begin
              first_fail <= dut_in;
              fail_seen  <= 1'b1;
            end
          end
          if (dut_in == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            dut_in <= dut_in + 1'b1;
            cnt    <= SETTLE_CNT;
            state  <= WAIT;
          end
        end
        DONE: begin
          // err_count is final here; pass becomes visible one cycle after done.
          pass  <= (err_count == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench for gate_sweep_ctrl: an AND-table controller (SETTLE=1) and an
// OR-table controller (SETTLE=0), each driving a selectable gate or fault model.
module tb_gate_sweep_ctrl;
  import gate_sweep_ctrl_pkg::*;

  typedef struct {
    int done_cyc;
    int err;
    int fs;
    int ff;
    int ps;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start     [2];
  logic [1:0] dut_in    [2];
  logic       dut_y     [2];
  logic       and_y     [2];
  logic       busy      [2];
  logic       done      [2];
  logic       pass      [2];
  logic [2:0] err_count [2];
  logic       fail_seen [2];
  logic [1:0] first_fail[2];

  int         mode[2];
  logic [3:0] mask[2];

  int   cyc = 0;
  int   nchecks = 0;
  int   nerrors = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  int   busy_run[2];
  int   pend[2];
  int   pend_exp[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .EXPECT(TT_AND2)) u_dut_and (
    .clk(clk), .rst(rst), .start(start[0]), .dut_in(dut_in[0]), .dut_y(dut_y[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
    .fail_seen(fail_seen[0]), .first_fail(first_fail[0])
  );

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(0), .EXPECT(TT_OR2)) u_dut_or (
    .clk(clk), .rst(rst), .start(start[1]), .dut_in(dut_in[1]), .dut_y(dut_y[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
    .fail_seen(fail_seen[1]), .first_fail(first_fail[1])
  );

  and_gate u_gate0 (.a(dut_in[0][1]), .b(dut_in[0][0]), .y(and_y[0]));
  and_gate u_gate1 (.a(dut_in[1][1]), .b(dut_in[1][0]), .y(and_y[1]));

  // Gate under test per controller: real gate, stuck-at faults or a per-vector flip mask.
  always_comb begin
    dut_y[0] = and_y[0];
    case (mode[0])
      1: dut_y[0] = 1'b0;
      2: dut_y[0] = 1'b1;
      3: dut_y[0] = and_y[0] ^ mask[0][dut_in[0]];
      default: ;
    endcase
    dut_y[1] = dut_in[1][1] | dut_in[1][0];
    case (mode[1])
      1: dut_y[1] = and_y[1];
      2: dut_y[1] = (dut_in[1][1] | dut_in[1][0]) ^ mask[1][dut_in[1]];
      default: ;
    endcase
  end

  function automatic int settle_of(input int g);
    return (g == 0) ? 1 : 0;
  endfunction

  // Reference: evaluate the selected gate on every vector, score against the table.
  function automatic exp_t model(input int g, input int m, input logic [3:0] mk, input int k);
    exp_t       e;
    logic [3:0] tt;
    int         a, b, y;
    tt    = (g == 0) ? 4'b1000 : 4'b1110;
    e.err = 0;
    e.ff  = 0;
    for (int v = 0; v < 4; v++) begin
      a = (v >> 1) & 1;
      b = v & 1;
      if (g == 0) begin
        case (m)
          0: y = a & b;
          1: y = 0;
          2: y = 1;
          default: y = (a & b) ^ int'(mk[v]);
        endcase
      end else begin
        case (m)
          0: y = a | b;
          1: y = a & b;
          default: y = (a | b) ^ int'(mk[v]);
        endcase
      end
      if (y != int'(tt[v])) begin
        if (e.err == 0) e.ff = v;
        e.err++;
      end
    end
    e.fs       = (e.err > 0) ? 1 : 0;
    e.ps       = (e.err == 0) ? 1 : 0;
    e.done_cyc = k + 4 * (settle_of(g) + 2);
    return e;
  endfunction

  task automatic chk(input string nm, input int g, input int act, input int expv);
    nchecks++;
    if (act != expv) begin
      nerrors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d (cycle %0d)", nm, g, act, expv, cyc);
    end
  endtask

  function automatic int qsize(input int g);
    return (g == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic push(input int g, input exp_t e);
    if (g == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic pop(input int g, output exp_t e);
    if (g == 0) e = sb0.pop_front();
    else        e = sb1.pop_front();
  endtask

  task automatic mon(input int g);
    exp_t e;
    int   s;
    s = settle_of(g);
    if (pend[g] != 0) begin
      chk("pass", g, int'(pass[g]), pend_exp[g]);
      pend[g] = 0;
    end
    if (busy[g]) begin
      chk("dut_in_seq", g, int'(dut_in[g]), busy_run[g] / (s + 2));
      busy_run[g]++;
    end
    if (done[g]) begin
      if (qsize(g) == 0) begin
        chk("unexpected_done", g, 1, 0);
      end else begin
        pop(g, e);
        chk("done_cycle", g, cyc, e.done_cyc);
        chk("err_count", g, int'(err_count[g]), e.err);
        chk("fail_seen", g, int'(fail_seen[g]), e.fs);
        if (e.fs != 0) chk("first_fail", g, int'(first_fail[g]), e.ff);
        chk("dut_in_final", g, int'(dut_in[g]), 3);
        chk("busy_cycles", g, busy_run[g], 4 * (s + 2));
        pend[g]     = 1;
        pend_exp[g] = e.ps;
      end
      busy_run[g] = 0;
    end else if (qsize(g) > 0) begin
      if (g == 0) e = sb0[0];
      else        e = sb1[0];
      if (cyc > e.done_cyc) begin
        chk("done_timeout", g, cyc, e.done_cyc);
        pop(g, e);
        busy_run[g] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    for (int g = 0; g < 2; g++) begin
      chk("rst_dut_in", g, int'(dut_in[g]), 0);
      chk("rst_busy", g, int'(busy[g]), 0);
      chk("rst_done", g, int'(done[g]), 0);
      chk("rst_pass", g, int'(pass[g]), 0);
      chk("rst_err_count", g, int'(err_count[g]), 0);
      chk("rst_fail_seen", g, int'(fail_seen[g]), 0);
      chk("rst_first_fail", g, int'(first_fail[g]), 0);
    end
  endtask

  task automatic issue(input int g, input int m, input logic [3:0] mk, output int k);
    mode[g]  = m;
    mask[g]  = mk;
    start[g] = 1'b1;
    k        = cyc + 1;
    push(g, model(g, m, mk, k));
    step();
    start[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while ((qsize(g) != 0 || pend[g] != 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("wait_idle_timeout", g, 1, 0);
  endtask

  task automatic pulse_at(input int g, input int edge_cyc);
    while (cyc < edge_cyc - 1) step();
    start[g] = 1'b1;
    step();
    start[g] = 1'b0;
  endtask

  initial begin
    int   k, k2, g, m, r, s;
    exp_t e;
    rst      = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    mode[0]  = 0;
    mode[1]  = 0;
    mask[0]  = 4'h0;
    mask[1]  = 4'h0;
    busy_run[0] = 0; busy_run[1] = 0;
    pend[0] = 0;     pend[1] = 0;
    repeat (2) step();
    check_reset_values();
    rst = 1'b0;
    step();

    // Directed: good AND gate, stuck-at-0, stuck-at-1.
    issue(0, 0, 4'h0, k); wait_idle(0);
    issue(0, 1, 4'h0, k); wait_idle(0);
    issue(0, 2, 4'h0, k); wait_idle(0);

    // Start re-pulsed mid-sweep must not disturb timing or results.
    issue(0, 0, 4'h0, k);
    pulse_at(0, k + 5);
    wait_idle(0);

    // Asynchronous reset mid-sweep, then a clean sweep.
    issue(0, 2, 4'h0, k);
    while (cyc < k + 5) step();
    #1 rst = 1'b1;
    #1;
    check_reset_values();
    sb0.delete();
    sb1.delete();
    busy_run[0] = 0; busy_run[1] = 0;
    pend[0] = 0;     pend[1] = 0;
    step();
    rst = 1'b0;
    step();
    issue(0, 0, 4'h0, k); wait_idle(0);

    // SETTLE=0 OR-table controller with OR gate, then with AND gate.
    issue(1, 0, 4'h0, k); wait_idle(1);
    issue(1, 1, 4'h0, k); wait_idle(1);

    // Start held through DONE: a second sweep starts on the first IDLE cycle.
    mode[0]  = 1;
    start[0] = 1'b1;
    k        = cyc + 1;
    e        = model(0, 1, 4'h0, k);
    push(0, e);
    k2       = e.done_cyc + 2;
    push(0, model(0, 1, 4'h0, k2));
    while (cyc < k2) step();
    start[0] = 1'b0;
    wait_idle(0);

    // Randomized sweeps with random fault masks, gaps and ignored re-starts.
    for (int it = 0; it < 24; it++) begin
      g = int'($urandom_range(0, 1));
      m = int'($urandom_range(0, (g == 0) ? 3 : 2));
      s = settle_of(g);
      repeat ($urandom_range(0, 3)) step();
      issue(g, m, 4'($urandom), k);
      if ($urandom_range(0, 1) == 1) begin
        r = int'($urandom_range(2, 4 * (s + 2) + 1));
        pulse_at(g, k + r);
      end
      wait_idle(g);
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
